// File: rtl/voicemail_controller.sv
// Voicemail controller: records 16-bit audio samples into a slotted message store and
// plays them back. It decodes voicemail_command and reports voicemail_status, and it owns
// the message table (per-entry lengths, logical-to-physical slot order) and delete compaction.
//
// Optional feature macro: VM_CALLER_ID_EN stores phn_num per physical slot at record
// start. When the macro is undefined, msg_phn_num is tied to zero.
//
// Ports:
//   clk, reset (async, active-high)
//   voicemail_command  level command: 0 NOP, 1 REC, 2 STOP, 3 PLAY, 4 DELETE
//   msg_sel            logical message index for PLAY/DELETE
//   phn_num            caller number latched at REC start
//   cf_present         CF card detected
//   ready / din        8 kHz sample strobe / sample to record
//   dout               playback sample
//   voicemail_status   0 NOCARD, 1 IDLE, 2 REC, 3 PLAY, 4 BUSY, 5 FULL, 6 EMPTY
//   msg_count          number of stored messages
//   overrun            sticky dropped-sample flag, cleared by the next accepted command
//   msg_phn_num        caller number of msg_sel
//   mem_req/mem_we/mem_addr/mem_wdata   memory request port ({phys_slot, offset})
//   mem_rdata/mem_ack                   read data and one-cycle completion
module voicemail_controller #(
    parameter int unsigned MAX_MSGS  = 8,
    parameter int unsigned MSG_WORDS = 4096,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned OFF_W     = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             voicemail_command,
    input  logic [IDX_W-1:0]       msg_sel,
    input  logic [7:0]             phn_num,
    input  logic                   cf_present,
    input  logic                   ready,
    input  logic [15:0]            din,
    output logic [15:0]            dout,
    output logic [3:0]             voicemail_status,
    output logic [IDX_W:0]         msg_count,
    output logic                   overrun,
    output logic [7:0]             msg_phn_num,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [IDX_W+OFF_W-1:0] mem_addr,
    output logic [15:0]            mem_wdata,
    input  logic [15:0]            mem_rdata,
    input  logic                   mem_ack
);
    localparam int unsigned LEN_W = OFF_W + 1;
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned ADR_W = IDX_W + OFF_W;

    localparam logic [3:0] CMD_NOP = 4'd0, CMD_REC = 4'd1, CMD_STOP = 4'd2,
                           CMD_PLAY = 4'd3, CMD_DEL = 4'd4;
    localparam logic [3:0] ST_NOCARD = 4'd0, ST_IDLE = 4'd1, ST_REC = 4'd2, ST_PLAY = 4'd3,
                           ST_BUSY = 4'd4, ST_FULL = 4'd5, ST_EMPTY = 4'd6;
    localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(MSG_WORDS - 1);

    typedef enum logic [2:0] {S_NOCARD, S_IDLE, S_REC, S_PLAY, S_DEL} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cmd_q, cmd_prev_q;
    logic [IDX_W-1:0]   slot_q, slot_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [LEN_W-1:0]   left_q, left_d;
    logic [IDX_W-1:0]   del_idx_q, del_idx_d;
    logic [IDX_W-1:0]   freed_q, freed_d;
    logic [IDX_W-1:0]   order_q [MAX_MSGS];
    logic [IDX_W-1:0]   order_d [MAX_MSGS];
    logic [LEN_W-1:0]   len_q [MAX_MSGS];
    logic [LEN_W-1:0]   len_d [MAX_MSGS];
    logic [CNT_W-1:0]   count_q, count_d;
    logic [3:0]         status_q, status_d;
    logic               overrun_q, overrun_d;
    logic [15:0]        dout_q, dout_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]        mem_wdata_q, mem_wdata_d;

    logic               fire, ack, can_issue, drop, accepted, rec_start;
    logic [OFF_W-1:0]   off_inc, off_nx;
    logic [LEN_W-1:0]   left_nx, stop_len;
    logic [3:0]         sticky;

    // Next-state, table update and memory-port logic
    always_comb begin
        // A command fires once, on the cycle after the input moves to a new nonzero code
        fire      = (cmd_q != cmd_prev_q) && (cmd_q != CMD_NOP);
        ack       = mem_ack && mem_req_q;
        can_issue = ready && (!mem_req_q || ack);
        drop      = ready && mem_req_q && !mem_ack;
        off_inc   = (off_q == OFF_MAX) ? off_q : off_q + 1'b1;
        off_nx    = ack ? off_inc : off_q;
        left_nx   = ack ? left_q - 1'b1 : left_q;
        stop_len  = LEN_W'(off_q) + LEN_W'(ack);

        state_d     = state_q;
        slot_d      = slot_q;
        off_d       = off_q;
        left_d      = left_q;
        del_idx_d   = del_idx_q;
        freed_d     = freed_q;
        order_d     = order_q;
        len_d       = len_q;
        count_d     = count_q;
        overrun_d   = overrun_q;
        dout_d      = dout_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        accepted    = 1'b0;
        rec_start   = 1'b0;
        sticky      = ST_NOCARD;

        if (!cf_present) begin
            // Card removal aborts any transfer; the table is left as it stands
            state_d   = S_NOCARD;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            dout_d    = '0;
        end else begin
            case (state_q)
                S_NOCARD: state_d = S_IDLE;
                S_IDLE: begin
                    if (fire) begin
                        case (cmd_q)
                            CMD_REC: begin
                                accepted = 1'b1;
                                if (count_q == CNT_W'(MAX_MSGS)) begin
                                    sticky = ST_FULL;
                                end else begin
                                    state_d   = S_REC;
                                    slot_d    = order_q[count_q[IDX_W-1:0]];
                                    off_d     = '0;
                                    rec_start = 1'b1;
                                end
                            end
                            CMD_PLAY: begin
                                accepted = 1'b1;
                                if (CNT_W'(msg_sel) >= count_q) begin
                                    sticky = ST_EMPTY;
                                end else begin
                                    state_d = S_PLAY;
                                    slot_d  = order_q[msg_sel];
                                    off_d   = '0;
                                    left_d  = len_q[msg_sel];
                                end
                            end
                            CMD_DEL: begin
                                accepted = 1'b1;
                                if (CNT_W'(msg_sel) >= count_q) begin
                                    sticky = ST_EMPTY;
                                end else begin
                                    state_d   = S_DEL;
                                    del_idx_d = msg_sel;
                                    freed_d   = order_q[msg_sel];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_REC: begin
                    if (ack) off_d = off_inc;
                    if (ack && off_q == OFF_MAX) begin
                        // Slot filled: close the message at full length
                        len_d[count_q[IDX_W-1:0]] = LEN_W'(MSG_WORDS);
                        count_d   = count_q + 1'b1;
                        state_d   = S_IDLE;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                    end else if (fire && cmd_q == CMD_STOP) begin
                        accepted = 1'b1;
                        if (stop_len != '0) begin
                            len_d[count_q[IDX_W-1:0]] = stop_len;
                            count_d = count_q + 1'b1;
                        end
                        state_d   = S_IDLE;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                    end else if (can_issue) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {slot_q, off_nx};
                        mem_wdata_d = din;
                    end else if (ack) begin
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                    end
                end
                S_PLAY: begin
                    if (ack) begin
                        dout_d = mem_rdata;
                        off_d  = off_inc;
                        left_d = left_nx;
                    end
                    if (fire && cmd_q == CMD_STOP) begin
                        accepted  = 1'b1;
                        dout_d    = '0;
                        state_d   = S_IDLE;
                        mem_req_d = 1'b0;
                    end else if (!mem_req_q && left_q == '0) begin
                        // Last sample was shown for one cycle; finish
                        dout_d  = '0;
                        state_d = S_IDLE;
                    end else if (can_issue && left_nx != '0) begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {slot_q, off_nx};
                    end else if (ack) begin
                        mem_req_d = 1'b0;
                    end
                end
                S_DEL: begin
                    // One table entry per cycle; the freed slot lands in the last used entry
                    if (CNT_W'(del_idx_q) == count_q - 1'b1) begin
                        order_d[del_idx_q] = freed_q;
                        len_d[del_idx_q]   = '0;
                        count_d            = count_q - 1'b1;
                        state_d            = S_IDLE;
                    end else begin
                        order_d[del_idx_q] = order_q[del_idx_q + 1'b1];
                        len_d[del_idx_q]   = len_q[del_idx_q + 1'b1];
                        del_idx_d          = del_idx_q + 1'b1;
                    end
                end
                default: state_d = S_NOCARD;
            endcase
            if (accepted) overrun_d = 1'b0;
            if (drop && (state_q == S_REC || state_q == S_PLAY)) overrun_d = 1'b1;
        end

        // FULL/EMPTY hold in IDLE until another command is accepted
        if (sticky != ST_NOCARD) begin
            status_d = sticky;
        end else if (state_d == S_IDLE && !accepted &&
                     (status_q == ST_FULL || status_q == ST_EMPTY)) begin
            status_d = status_q;
        end else begin
            case (state_d)
                S_IDLE:  status_d = ST_IDLE;
                S_REC:   status_d = ST_REC;
                S_PLAY:  status_d = ST_PLAY;
                S_DEL:   status_d = ST_BUSY;
                default: status_d = ST_NOCARD;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_NOCARD;
            cmd_q       <= CMD_NOP;
            cmd_prev_q  <= CMD_NOP;
            slot_q      <= '0;
            off_q       <= '0;
            left_q      <= '0;
            del_idx_q   <= '0;
            freed_q     <= '0;
            for (int i = 0; i < int'(MAX_MSGS); i++) begin
                order_q[i] <= IDX_W'(i);
                len_q[i]   <= '0;
            end
            count_q     <= '0;
            status_q    <= ST_NOCARD;
            overrun_q   <= 1'b0;
            dout_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= voicemail_command;
            cmd_prev_q  <= cmd_q;
            slot_q      <= slot_d;
            off_q       <= off_d;
            left_q      <= left_d;
            del_idx_q   <= del_idx_d;
            freed_q     <= freed_d;
            order_q     <= order_d;
            len_q       <= len_d;
            count_q     <= count_d;
            status_q    <= status_d;
            overrun_q   <= overrun_d;
            dout_q      <= dout_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef VM_CALLER_ID_EN
    // Caller numbers live per physical slot, so they follow the order table implicitly
    logic [7:0] phn_q [MAX_MSGS];
    logic [7:0] msg_phn_num_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(MAX_MSGS); i++) phn_q[i] <= '0;
            msg_phn_num_q <= '0;
        end else begin
            if (rec_start) phn_q[slot_d] <= phn_num;
            msg_phn_num_q <= (CNT_W'(msg_sel) < count_q) ? phn_q[order_q[msg_sel]] : 8'h00;
        end
    end
    assign msg_phn_num = msg_phn_num_q;
`else
    logic unused_caller_id;
    assign unused_caller_id = ^{phn_num, rec_start};
    assign msg_phn_num      = 8'h00;
`endif

    assign dout             = dout_q;
    assign voicemail_status = status_q;
    assign msg_count        = count_q;
    assign overrun          = overrun_q;
    assign mem_req          = mem_req_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
endmodule

// File: tb/tb_voicemail_controller.sv
// Directed bench for voicemail_controller: card detect, record, playback, empty/full
// handling, delete compaction, overrun and card removal mid-record.
module tb_voicemail_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  voicemail_command;
    logic [2:0]  msg_sel;
    logic [7:0]  phn_num;
    logic        cf_present;
    logic        ready;
    logic [15:0] din;
    logic [15:0] dout;
    logic [3:0]  voicemail_status;
    logic [3:0]  msg_count;
    logic        overrun;
    logic [7:0]  msg_phn_num;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    int total = 0;
    int bad   = 0;

    voicemail_controller dut (
        .clk               (clk),
        .reset             (reset),
        .voicemail_command (voicemail_command),
        .msg_sel           (msg_sel),
        .phn_num           (phn_num),
        .cf_present        (cf_present),
        .ready             (ready),
        .din               (din),
        .dout              (dout),
        .voicemail_status  (voicemail_status),
        .msg_count         (msg_count),
        .overrun           (overrun),
        .msg_phn_num       (msg_phn_num),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command for two edges (register + execute), then return to NOP
    task automatic send(input logic [3:0] c);
        voicemail_command = c;
        step(2);
        voicemail_command = 4'd0;
    endtask

    task automatic rec_word(input logic [14:0] exp_addr, input logic [15:0] d);
        din = d; ready = 1'b1; step(1); ready = 1'b0;
        chk("wr_req", 32'(mem_req), 32'd1);
        chk("wr_we", 32'(mem_we), 32'd1);
        chk("wr_addr", 32'(mem_addr), 32'(exp_addr));
        chk("wr_data", 32'(mem_wdata), 32'(d));
        step(1); mem_ack = 1'b1; step(1); mem_ack = 1'b0;
        chk("wr_done", 32'(mem_req), 32'd0);
    endtask

    task automatic play_word(input logic [14:0] exp_addr, input logic [15:0] rd);
        ready = 1'b1; step(1); ready = 1'b0;
        chk("rd_req", 32'(mem_req), 32'd1);
        chk("rd_we", 32'(mem_we), 32'd0);
        chk("rd_addr", 32'(mem_addr), 32'(exp_addr));
        step(1); mem_rdata = rd; mem_ack = 1'b1; step(1); mem_ack = 1'b0;
        chk("rd_dout", 32'(dout), 32'(rd));
    endtask

    initial begin
        reset = 1'b1; voicemail_command = 4'd0; msg_sel = 3'd0; phn_num = 8'h00;
        cf_present = 1'b0; ready = 1'b0; din = 16'h0; mem_rdata = 16'h0; mem_ack = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);

        // Reset values
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_status", 32'(voicemail_status), 32'd0);
        chk("rst_count", 32'(msg_count), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_phn", 32'(msg_phn_num), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);

        // No card, then card inserted
        step(2);
        chk("nocard_status", 32'(voicemail_status), 32'd0);
        cf_present = 1'b1;
        step(1);
        chk("card_status", 32'(voicemail_status), 32'd1);

        // STOP in IDLE has no effect
        send(4'd2);
        step(1);
        chk("stop_idle_status", 32'(voicemail_status), 32'd1);
        chk("stop_idle_req", 32'(mem_req), 32'd0);

        // Record five samples into slot 0, then STOP
        send(4'd1);
        chk("rec_status", 32'(voicemail_status), 32'd2);
        for (int n = 0; n < 5; n++) rec_word(15'(n), 16'(16'h1000 + n));
        send(4'd2);
        chk("rec1_count", 32'(msg_count), 32'd1);
        chk("rec1_status", 32'(voicemail_status), 32'd1);

        // Play it back
        msg_sel = 3'd0;
        send(4'd3);
        chk("play_status", 32'(voicemail_status), 32'd3);
        for (int n = 0; n < 5; n++) play_word(15'(n), 16'(16'hA5A5 + n));
        step(1);
        chk("play_end_dout", 32'(dout), 32'd0);
        chk("play_end_status", 32'(voicemail_status), 32'd1);

        // PLAY past the end -> EMPTY, persisting while idle
        msg_sel = 3'd3;
        send(4'd3);
        step(2);
        chk("empty_status", 32'(voicemail_status), 32'd6);

        // REC then immediate STOP: zero-length message discarded
        send(4'd1);
        chk("rec0_status", 32'(voicemail_status), 32'd2);
        send(4'd2);
        chk("rec0_count", 32'(msg_count), 32'd1);

        // Fill remaining slots with one-sample messages in physical order
        for (int k = 1; k < 8; k++) begin
            send(4'd1);
            rec_word(15'(k << 12), 16'(16'h2000 + k));
            send(4'd2);
        end
        chk("fill_count", 32'(msg_count), 32'd8);
        send(4'd1);
        chk("full_status", 32'(voicemail_status), 32'd5);
        chk("full_req", 32'(mem_req), 32'd0);

        // Delete logical 0: BUSY for eight cycles
        msg_sel = 3'd0;
        send(4'd4);
        chk("del_busy0", 32'(voicemail_status), 32'd4);
        for (int i = 1; i < 8; i++) begin
            step(1);
            chk("del_busy", 32'(voicemail_status), 32'd4);
        end
        step(1);
        chk("del_done_status", 32'(voicemail_status), 32'd1);
        chk("del_done_count", 32'(msg_count), 32'd7);

        // Logical 0 is now physical slot 1 (one sample)
        send(4'd3);
        play_word(15'h1000, 16'h2001);
        step(1);
        chk("play_shift_status", 32'(voicemail_status), 32'd1);
        chk("play_shift_dout", 32'(dout), 32'd0);

        // Next recording reuses freed physical slot 0; two strobes without ack -> overrun
        send(4'd1);
        din = 16'h3333; ready = 1'b1; step(1); ready = 1'b0;
        step(1);
        din = 16'h4444; ready = 1'b1; step(1); ready = 1'b0;
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_addr", 32'(mem_addr), 32'd0);
        chk("ovr_data", 32'(mem_wdata), 32'h3333);
        mem_ack = 1'b1; step(1); mem_ack = 1'b0;
        chk("ovr_one_write", 32'(mem_req), 32'd0);

        // Card pulled mid-record
        din = 16'h5555; ready = 1'b1; step(1); ready = 1'b0;
        chk("pull_req_before", 32'(mem_req), 32'd1);
        cf_present = 1'b0;
        step(1);
        chk("pull_req", 32'(mem_req), 32'd0);
        chk("pull_status", 32'(voicemail_status), 32'd0);
        chk("pull_count", 32'(msg_count), 32'd7);
        chk("pull_overrun", 32'(overrun), 32'd1);
        chk("phn_default", 32'(msg_phn_num), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
